// File: rtl/ulpi_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : ulpi_pkg
//  Description : Shared tag encodings, drain FSM states and default markers
//                for the ULPI receive logger.
//  Revision    : 1.0 - initial release
// ============================================================================
package ulpi_pkg;

    localparam int ENTRY_W = 10;

    localparam logic [1:0] TAG_DATA  = 2'd0;
    localparam logic [1:0] TAG_RXCMD = 2'd1;
    localparam logic [1:0] TAG_EOP   = 2'd2;

    localparam int         ST_W         = 3;
    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_FETCH     = 3'd1;
    localparam logic [2:0] ST_SEND_SOP  = 3'd2;
    localparam logic [2:0] ST_SEND_ESC  = 3'd3;
    localparam logic [2:0] ST_SEND_BYTE = 3'd4;
    localparam logic [2:0] ST_WAIT      = 3'd5;

    localparam logic [7:0] DEF_SOP_MARK = 8'hA5;
    localparam logic [7:0] DEF_EOP_MARK = 8'h5A;
    localparam logic [7:0] DEF_ESC_MARK = 8'hDB;
    localparam logic [7:0] ESC_XOR      = 8'h20;
    localparam logic [7:0] RXCMD_ID     = 8'h01;

    function automatic logic needs_escape(input logic [7:0] b,
                                          input logic [7:0] sop,
                                          input logic [7:0] eop,
                                          input logic [7:0] esc);
        return (b == sop) || (b == eop) || (b == esc);
    endfunction

endpackage
`default_nettype wire

// File: rtl/ulpi_rx_fifo.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : ulpi_rx_fifo
//  Description : Circular buffer of 10-bit tagged entries with wrapping
//                pointers, occupancy level, full and almost_full flags.
//  Revision    : 1.0 - initial release
// ============================================================================
module ulpi_rx_fifo
    import ulpi_pkg::*;
#(
    parameter int DEPTH = 64
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [ENTRY_W-1:0]       wr_data,
    input  logic                     pop,
    output logic [ENTRY_W-1:0]       rd_data,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     full,
    output logic                     almost_full
);

    localparam int            AW        = $clog2(DEPTH);
    localparam logic [AW:0]   LVL_FULL  = (AW+1)'(DEPTH);
    localparam logic [AW:0]   LVL_AFULL = (AW+1)'(DEPTH - 1);

    logic [ENTRY_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [AW:0]        level_q, level_d;
    logic               push_ok, pop_ok;

    always_comb begin
        push_ok  = push && (level_q != LVL_FULL);
        pop_ok   = pop && (level_q != '0);
        wr_ptr_d = push_ok ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop_ok  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        level_d  = level_q;
        case ({push_ok, pop_ok})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage carries no reset; only the pointers define validity.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    assign rd_data     = mem_q[rd_ptr_q];
    assign level       = level_q;
    assign full        = (level_q == LVL_FULL);
    assign almost_full = (level_q >= LVL_AFULL);

endmodule
`default_nettype wire

// File: rtl/ulpi_rx_logger.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : ulpi_rx_logger
//  Description : Snoops ULPI receive traffic, buffers tagged entries and
//                streams them as framed, escaped bytes to a UART.
//                Define ULPI_RXCMD_LOG_EN to also log RXCMD bytes.
//  Revision    : 1.0 - initial release
// ============================================================================
module ulpi_rx_logger
    import ulpi_pkg::*;
#(
    parameter int         DEPTH    = 64,
    parameter logic [7:0] SOP_MARK = DEF_SOP_MARK,
    parameter logic [7:0] EOP_MARK = DEF_EOP_MARK,
    parameter logic [7:0] ESC_MARK = DEF_ESC_MARK
) (
    input  logic                     clk_ext,
    input  logic                     rst_n,
    input  logic [7:0]               DATA,
    input  logic                     DIR,
    input  logic                     NXT,
    output logic                     STP,
    output logic [7:0]               tx_data,
    output logic                     tx_send,
    input  logic                     tx_busy,
    output logic                     overflow,
    output logic [7:0]               drop_cnt,
    output logic [$clog2(DEPTH):0]   level
);

    logic                dir_q, dir_d;
    logic                seen_data_q, seen_data_d;
    logic                overflow_q, overflow_d;
    logic [7:0]          drop_cnt_q, drop_cnt_d;
    logic [ST_W-1:0]     state_q, state_d;
    logic [ST_W-1:0]     ret_q, ret_d;
    logic [ENTRY_W-1:0]  cur_q, cur_d;
    logic                open_q, open_d;
    logic                skip_q, skip_d;
    logic                tx_send_q, tx_send_d;
    logic [7:0]          tx_data_q, tx_data_d;
`ifdef ULPI_RXCMD_LOG_EN
    logic                phase_q, phase_d;
    logic                act_phase;
`endif

    logic                fifo_push, fifo_pop, fifo_full, fifo_afull, drop;
    logic [ENTRY_W-1:0]  fifo_wr, fifo_rd;
    logic                dir_rise, dir_fall, cap_data;

    logic [1:0]          head_tag, act_tag;
    logic [7:0]          head_byte, act_byte, byte_out;
    logic                act_esc, emit;
    logic [ST_W-1:0]     first_step, act_step;
    logic [ENTRY_W-1:0]  act_entry;

    ulpi_rx_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk         (clk_ext),
        .rst_n       (rst_n),
        .push        (fifo_push),
        .wr_data     (fifo_wr),
        .pop         (fifo_pop),
        .rd_data     (fifo_rd),
        .level       (level),
        .full        (fifo_full),
        .almost_full (fifo_afull)
    );

    // Capture: the last slot is kept free so a packet can always be closed.
    always_comb begin
        dir_d       = DIR;
        dir_rise    = DIR && !dir_q;
        dir_fall    = !DIR && dir_q;
        cap_data    = DIR && dir_q && NXT;
        fifo_push   = 1'b0;
        fifo_wr     = {TAG_DATA, DATA};
        drop        = 1'b0;
        seen_data_d = dir_rise ? 1'b0 : seen_data_q;
        if (cap_data) begin
            if (!fifo_afull) begin
                fifo_push   = 1'b1;
                seen_data_d = 1'b1;
            end else begin
                drop = 1'b1;
            end
        end
`ifdef ULPI_RXCMD_LOG_EN
        else if (DIR && dir_q && !NXT) begin
            fifo_wr = {TAG_RXCMD, DATA};
            if (!fifo_afull) fifo_push = 1'b1;
            else             drop      = 1'b1;
        end
`endif
        else if (dir_fall && seen_data_q) begin
            fifo_wr = {TAG_EOP, 8'h00};
            if (!fifo_full) fifo_push = 1'b1;
            else            drop      = 1'b1;
        end
        overflow_d = overflow_q || drop;
        drop_cnt_d = (drop && (drop_cnt_q != 8'hFF)) ? drop_cnt_q + 8'd1 : drop_cnt_q;
    end

    // FETCH issues the first byte of an entry directly when the UART is idle.
    always_comb begin
        head_tag   = fifo_rd[9:8];
        head_byte  = fifo_rd[7:0];
        first_step = ST_SEND_BYTE;
        if (head_tag == TAG_DATA) begin
            if (!open_q)
                first_step = ST_SEND_SOP;
            else if (needs_escape(head_byte, SOP_MARK, EOP_MARK, ESC_MARK))
                first_step = ST_SEND_ESC;
        end
`ifdef ULPI_RXCMD_LOG_EN
        else if (head_tag == TAG_RXCMD) begin
            first_step = ST_SEND_ESC;
        end
        act_phase = (state_q == ST_FETCH) ? 1'b0 : phase_q;
`endif
        act_step  = (state_q == ST_FETCH) ? first_step : state_q;
        act_entry = (state_q == ST_FETCH) ? fifo_rd : cur_q;
        act_tag   = act_entry[9:8];
        act_byte  = act_entry[7:0];
        act_esc   = needs_escape(act_byte, SOP_MARK, EOP_MARK, ESC_MARK);
        emit      = !tx_busy && ((state_q == ST_FETCH) || (state_q == ST_SEND_SOP) ||
                                 (state_q == ST_SEND_ESC) || (state_q == ST_SEND_BYTE));
        byte_out  = EOP_MARK;
        if (act_tag == TAG_DATA)
            byte_out = act_esc ? (act_byte ^ ESC_XOR) : act_byte;
`ifdef ULPI_RXCMD_LOG_EN
        else if (act_tag == TAG_RXCMD)
            byte_out = act_phase ? act_byte : RXCMD_ID;
`endif
    end

    always_ff @(posedge clk_ext or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:      if ((level != '0) && !tx_busy) state_d = ST_FETCH;
            ST_FETCH:     state_d = emit ? ST_WAIT : first_step;
            ST_SEND_SOP,
            ST_SEND_ESC,
            ST_SEND_BYTE: if (emit) state_d = ST_WAIT;
            ST_WAIT:      if (!skip_q && !tx_busy) state_d = ret_q;
            default:      state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        fifo_pop  = (state_q == ST_FETCH);
        cur_d     = cur_q;
        open_d    = open_q;
        ret_d     = ret_q;
        skip_d    = emit;
        tx_send_d = emit;
        tx_data_d = tx_data_q;
`ifdef ULPI_RXCMD_LOG_EN
        phase_d   = (state_q == ST_FETCH) ? 1'b0 : phase_q;
`endif
        if (state_q == ST_FETCH) begin
            cur_d = fifo_rd;
            if (head_tag == TAG_DATA) open_d = 1'b1;
            if (head_tag == TAG_EOP)  open_d = 1'b0;
        end
        if (emit) begin
            case (act_step)
                ST_SEND_SOP: begin
                    tx_data_d = SOP_MARK;
                    ret_d     = act_esc ? ST_SEND_ESC : ST_SEND_BYTE;
                end
                ST_SEND_ESC: begin
                    tx_data_d = ESC_MARK;
                    ret_d     = ST_SEND_BYTE;
                end
                default: begin
                    tx_data_d = byte_out;
                    ret_d     = ST_IDLE;
`ifdef ULPI_RXCMD_LOG_EN
                    if ((act_tag == TAG_RXCMD) && !act_phase) begin
                        ret_d   = ST_SEND_BYTE;
                        phase_d = 1'b1;
                    end
`endif
                end
            endcase
        end
    end

    always_ff @(posedge clk_ext or negedge rst_n) begin
        if (!rst_n) begin
            dir_q       <= 1'b0;
            seen_data_q <= 1'b0;
            overflow_q  <= 1'b0;
            drop_cnt_q  <= '0;
            ret_q       <= ST_IDLE;
            cur_q       <= '0;
            open_q      <= 1'b0;
            skip_q      <= 1'b0;
            tx_send_q   <= 1'b0;
            tx_data_q   <= '0;
`ifdef ULPI_RXCMD_LOG_EN
            phase_q     <= 1'b0;
`endif
        end else begin
            dir_q       <= dir_d;
            seen_data_q <= seen_data_d;
            overflow_q  <= overflow_d;
            drop_cnt_q  <= drop_cnt_d;
            ret_q       <= ret_d;
            cur_q       <= cur_d;
            open_q      <= open_d;
            skip_q      <= skip_d;
            tx_send_q   <= tx_send_d;
            tx_data_q   <= tx_data_d;
`ifdef ULPI_RXCMD_LOG_EN
            phase_q     <= phase_d;
`endif
        end
    end

    assign STP      = 1'b0;
    assign tx_send  = tx_send_q;
    assign tx_data  = tx_data_q;
    assign overflow = overflow_q;
    assign drop_cnt = drop_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_ulpi_rx_logger.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_ulpi_rx_logger
//  Description : Directed self-checking bench for ulpi_rx_logger (DEPTH=4).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ulpi_rx_logger;

    localparam int DEPTH = 4;

    logic       clk_ext = 1'b0;
    logic       rst_n   = 1'b0;
    logic [7:0] DATA    = 8'h00;
    logic       DIR     = 1'b0;
    logic       NXT     = 1'b0;
    logic       STP;
    logic [7:0] tx_data;
    logic       tx_send;
    logic       tx_busy;
    logic       overflow;
    logic [7:0] drop_cnt;
    logic [2:0] level;

    int         tests = 0;
    int         fails = 0;
    logic [7:0] rx_q[$];
    logic [7:0] exp_q[$];
    logic [7:0] pkt_q[$];
    int         rx_base   = 0;
    int         busy_cnt  = 0;
    int         max_level = 0;
    bit         auto_busy = 1'b0;
    bit         force_busy = 1'b0;

    ulpi_rx_logger #(.DEPTH(DEPTH)) dut (
        .clk_ext  (clk_ext),
        .rst_n    (rst_n),
        .DATA     (DATA),
        .DIR      (DIR),
        .NXT      (NXT),
        .STP      (STP),
        .tx_data  (tx_data),
        .tx_send  (tx_send),
        .tx_busy  (tx_busy),
        .overflow (overflow),
        .drop_cnt (drop_cnt),
        .level    (level)
    );

    always #8 clk_ext = ~clk_ext;

    assign tx_busy = force_busy || (busy_cnt != 0);

    // UART model: records strobed bytes and optionally stays busy for a while.
    always @(negedge clk_ext) begin
        if (tx_send) rx_q.push_back(tx_data);
        if (tx_send && auto_busy) busy_cnt = 3;
        else if (busy_cnt > 0)    busy_cnt = busy_cnt - 1;
        if (int'(level) > max_level) max_level = int'(level);
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk_ext);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_pkt();
        DIR = 1'b1; NXT = 1'b0; DATA = 8'h00; tick();
        foreach (pkt_q[i]) begin
            NXT = 1'b1; DATA = pkt_q[i]; tick();
        end
        DIR = 1'b0; NXT = 1'b0; DATA = 8'hFF; tick();
        DATA = 8'h00;
    endtask

    task automatic check_rx(input string tag);
        int n;
        for (int i = 0; i < 600 && (rx_q.size() - rx_base) < exp_q.size(); i++) tick();
        repeat (30) tick();
        n = rx_q.size() - rx_base;
        chk({tag, "_len"}, n, exp_q.size());
        for (int i = 0; i < exp_q.size() && i < n; i++)
            chk($sformatf("%s_b%0d", tag, i), rx_q[rx_base + i], exp_q[i]);
        chk({tag, "_level"}, level, 0);
        rx_base = rx_q.size();
    endtask

    initial begin
        // Reset values
        repeat (3) tick();
        chk("rst_tx_send", tx_send, 0);
        chk("rst_tx_data", tx_data, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_drop_cnt", drop_cnt, 0);
        chk("rst_level", level, 0);
        chk("rst_stp", STP, 0);
        rst_n = 1'b1;
        repeat (2) tick();

        // Basic packet with a slow UART
        auto_busy = 1'b1;
        pkt_q = '{8'h01, 8'h02, 8'h03};
        send_pkt();
        exp_q = '{8'hA5, 8'h01, 8'h02, 8'h03, 8'h5A};
        check_rx("basic");

        // Escaping plus first-strobe latency and push/pop level
        DIR = 1'b1; NXT = 1'b0; tick();
        NXT = 1'b1; DATA = 8'hA5; tick();
        chk("lat_e1_send", tx_send, 0);
        DATA = 8'hDB; tick();
        chk("lat_e2_send", tx_send, 0);
        DIR = 1'b0; NXT = 1'b0; DATA = 8'h00; tick();
        chk("lat_e3_send", tx_send, 1);
        chk("lat_e3_data", tx_data, 8'hA5);
        chk("pushpop_level", level, 2);
        exp_q = '{8'hA5, 8'hDB, 8'h85, 8'hDB, 8'hFB, 8'h5A};
        check_rx("escape");

        // RXCMD-only bus turn
        DIR = 1'b1; NXT = 1'b0; DATA = 8'h00; tick();
        DATA = 8'h4E; tick();
        DIR = 1'b0; DATA = 8'h00; tick();
`ifdef ULPI_RXCMD_LOG_EN
        exp_q = '{8'hDB, 8'h01, 8'h4E};
`else
        exp_q.delete();
`endif
        check_rx("rxcmd");

        // Overflow with the UART held busy
        force_busy = 1'b1;
        pkt_q = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15};
        send_pkt();
        tick();
        chk("ovf_flag", overflow, 1);
        chk("ovf_drop_cnt", drop_cnt, 3);
        chk("ovf_level", level, 4);
        chk("ovf_no_send", rx_q.size() - rx_base, 0);
        force_busy = 1'b0;
        exp_q = '{8'hA5, 8'h10, 8'h11, 8'h12, 8'h5A};
        check_rx("ovf_drain");
        chk("ovf_sticky", overflow, 1);

        // Packets arriving while the previous one drains
        auto_busy = 1'b0;
        pkt_q = '{8'h11};
        send_pkt();
        repeat (4) tick();
        pkt_q = '{8'h5A};
        send_pkt();
        exp_q = '{8'hA5, 8'h11, 8'h5A, 8'hA5, 8'hDB, 8'h7A, 8'h5A};
        check_rx("concur");
        chk("concur_no_drop", drop_cnt, 3);
        chk("max_level_le_depth", (max_level <= DEPTH), 1);

        // Reset in the middle of the second byte
        auto_busy = 1'b1;
        pkt_q = '{8'h01, 8'h02, 8'h03};
        send_pkt();
        for (int i = 0; i < 300 && (rx_q.size() - rx_base) < 2; i++) tick();
        chk("mid_trigger", rx_q.size() - rx_base, 2);
        @(negedge clk_ext);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_tx_send", tx_send, 0);
        chk("mid_tx_data", tx_data, 0);
        chk("mid_overflow", overflow, 0);
        chk("mid_drop_cnt", drop_cnt, 0);
        chk("mid_level", level, 0);
        chk("mid_stp", STP, 0);
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (25) tick();
        chk("mid_silent", rx_q.size() - rx_base, 2);
        rx_base = rx_q.size();
        pkt_q = '{8'h07};
        send_pkt();
        exp_q = '{8'hA5, 8'h07, 8'h5A};
        check_rx("after_rst");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
